mmio_wr_fifo: RTL and testbench
===============================

Name: mmio_wr_fifo

Overview:
- Circular buffer that captures host MMIO writes to the user data CSR (16'h0020) and returns them in order on MMIO reads of the same CSR.
- Upstream is the AFU MMIO write decode; downstream is the AFU MMIO read-response mux (tx.c2.data).
- Adds occupancy, full/empty and sticky overflow/underflow status, read back through a status CSR (16'h0022) that the AFU assembles.

Parameters:
- DEPTH, 8, number of 64-bit entries; power of two, minimum 2.
- WIDTH, 64, data width in bits; matches CCI-P MMIO 64-bit data.

Ports:
- clk  in  1  AFU clock.
- rst  in  1  synchronous, active-high reset.
- push_i  in  1  one-cycle strobe: MMIO write valid and address == 16'h0020.
- push_data_i  in  WIDTH  write data (rx.c0.data[63:0]).
- pop_i  in  1  one-cycle strobe: MMIO read valid and address == 16'h0020.
- pop_data_o  out  WIDTH  registered head data, valid the cycle after pop_i.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- overflow_o  out  1  sticky: a push was dropped while full.
- underflow_o  out  1  sticky: a pop was issued while empty.
- clr_flags_i  in  1  one-cycle strobe: MMIO write to 16'h0022; clears both sticky flags.

Behaviour:
- Reset values on a synchronous rst at the clock edge:
  - wr_ptr and rd_ptr are 0; count_o is 0.
  - pop_data_o is 0; empty_o is 1; full_o is 0.
  - overflow_o and underflow_o are 0.
  - Storage contents are not reset.
- rst overrides all other inputs in the same cycle. A push or pop coincident with rst is discarded.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count_o is kept as a separate register.
- All decisions use the pre-edge state (count before the clock edge).
- Push:
  - If not full, write push_data_i at wr_ptr and increment wr_ptr.
  - If full and no pop is in the same cycle, drop the data and set overflow_o.
- Pop:
  - If not empty, pop_data_o <= mem[rd_ptr] and increment rd_ptr. Latency is 1 cycle, which meets the CCI-P MMIO read response timing when the AFU registers tx.c2 from pop_data_o.
  - If empty, pop_data_o <= 0 and set underflow_o; pointers are unchanged.
- Simultaneous push and pop:
  - Not empty, not full: both occur and count_o is unchanged.
  - Full: the pop frees a slot, so the push is accepted; no overflow; count_o stays DEPTH.
  - Empty: the pop underflows (returns 0, sets underflow_o) and the push is accepted; count_o becomes 1. There is no fall-through bypass.
- count_o update: +1 on push only, -1 on pop only, unchanged on both or neither (accepted operations only).
- full_o and empty_o are decoded combinationally from registered count_o.
- clr_flags_i:
  - Clears the sticky flags at the edge.
  - If an overflow or underflow event occurs in the same cycle, the set wins (the flag is 1 after the edge).
- pop_data_o holds its value between pops.

Optional Feature:
- Macro: MMIO_WR_FIFO_HWM_EN.
- Defined:
  - Adds output hwm_o ($clog2(DEPTH)+1 bits): the high-water mark, i.e. the maximum count_o value since reset or the last clr_flags_i.
  - hwm_o <= max(hwm_o, next count). On clr_flags_i, hwm_o <= next count.
  - Reset value is 0.
- Undefined: the hwm_o port and its register are absent. All other behaviour is identical.

Decomposition:
- Package mmio_wr_fifo_pkg holds:
  - Constants MMIO_FIFO_DATA_ADDR = 16'h0020 and MMIO_FIFO_STAT_ADDR = 16'h0022.
  - Default DEPTH and WIDTH.
  - A typedef t_fifo_status packing {underflow, overflow, full, empty, count}, zero-extended to 64 bits for the status CSR read.
- One sub-module, mmio_wr_fifo_ram: simple dual-port storage with a registered read port, no reset. Pointer, count and flag logic stay in mmio_wr_fifo.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333; pop three times → pop_data_o is 0x1111, 0x2222, 0x3333 on successive post-pop cycles; count_o goes 3→0; empty_o is 1 at the end.
- Push 9 values (0xA0..0xA8) with DEPTH=8 → full_o is 1 after the 8th; the 9th is dropped; overflow_o is 1; 8 pops return 0xA0..0xA7.
- Pop while empty → pop_data_o is 0 and underflow_o is 1; then pulse clr_flags_i → both flags are 0; count_o is still 0.
- Fill to 8, then push 0xBB and pop in the same cycle → pop returns the oldest entry; no overflow; count_o stays 8; 0xBB is the last entry drained.
- Empty FIFO, push 0xCC and pop in the same cycle → pop_data_o is 0, underflow_o is 1, count_o is 1; the next pop returns 0xCC.
- With MMIO_WR_FIFO_HWM_EN: push 5, pop 3 → hwm_o is 5; clr_flags_i → hwm_o is 2. Also assert rst mid-sequence with push_i high → count_o is 0 and hwm_o is 0 the next cycle.

Source files
------------

// File: rtl/mmio_wr_fifo_pkg.sv
// Shared constants and status CSR layout for the MMIO user-data write FIFO.
// Optional high-water mark tracking is enabled by MMIO_WR_FIFO_HWM_EN.
package mmio_wr_fifo_pkg;

  localparam logic [15:0] MMIO_FIFO_DATA_ADDR = 16'h0020;
  localparam logic [15:0] MMIO_FIFO_STAT_ADDR = 16'h0022;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 64;
  localparam int FIFO_CNT_W     = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef struct packed {
    logic                  underflow;
    logic                  overflow;
    logic                  full;
    logic                  empty;
    logic [FIFO_CNT_W-1:0] count;
  } t_fifo_status;

  localparam int STAT_PAD_W = 64 - $bits(t_fifo_status);

  // Status word as the host sees it on a read of MMIO_FIFO_STAT_ADDR.
  function automatic logic [63:0] fifo_status_csr(input t_fifo_status s);
    return {{STAT_PAD_W{1'b0}}, s};
  endfunction

endpackage

// File: rtl/mmio_wr_fifo_ram.sv
// Simple dual-port storage for the MMIO write FIFO: one write port, one
// registered read port. No reset on the array or the read register.
module mmio_wr_fifo_ram
  import mmio_wr_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a pop and push to the same slot (full FIFO) returns
  // the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end

endmodule

// File: rtl/mmio_wr_fifo.sv
// Circular buffer capturing host MMIO writes to the user data CSR and
// returning them in order on reads. Optional hwm_o under MMIO_WR_FIFO_HWM_EN.
module mmio_wr_fifo
  import mmio_wr_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
`ifdef MMIO_WR_FIFO_HWM_EN
  output logic [$clog2(DEPTH):0] hwm_o,
`endif
  input  logic                   clr_flags_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_acc, pop_acc;
  logic             ovf_ev, udf_ev;
  logic             rd_vld;
  logic [WIDTH-1:0] ram_q;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);

  // A pop on a full FIFO frees the slot the coincident push lands in.
  always_comb begin
    push_acc  = push_i && (!full_o || pop_i);
    pop_acc   = pop_i && !empty_o;
    ovf_ev    = push_i && full_o && !pop_i;
    udf_ev    = pop_i && empty_o;
    count_nxt = count_o;
    if (push_acc && !pop_acc)      count_nxt = count_o + CW'(1);
    else if (!push_acc && pop_acc) count_nxt = count_o - CW'(1);
  end

  mmio_wr_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_acc && !rst),
    .wr_addr (wr_ptr),
    .wr_data (push_data_i),
    .rd_en   (pop_acc && !rst),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      rd_vld      <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      // rd_vld tracks whether the last pop returned real data; it holds
      // between pops so pop_data_o holds too.
      if (pop_i)    rd_vld <= pop_acc;
      count_o     <= count_nxt;
      overflow_o  <= ovf_ev | (overflow_o  & ~clr_flags_i);
      underflow_o <= udf_ev | (underflow_o & ~clr_flags_i);
    end
  end

  // Read register is unreset; the valid bit forces 0 after reset/underflow.
  assign pop_data_o = rd_vld ? ram_q : '0;

`ifdef MMIO_WR_FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)                    hwm_o <= '0;
    else if (clr_flags_i)       hwm_o <= count_nxt;
    else if (count_nxt > hwm_o) hwm_o <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_mmio_wr_fifo.sv
// Self-checking bench for mmio_wr_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model. Honours MMIO_WR_FIFO_HWM_EN.
module tb_mmio_wr_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, push, pop, clr;
  logic [WIDTH-1:0] push_data, pop_data;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, udf;
`ifdef MMIO_WR_FIFO_HWM_EN
  logic [CW-1:0]    hwm;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] m_data;
  bit               m_ovf, m_udf;
  int               m_hwm;

  mmio_wr_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (ovf),
    .underflow_o (udf),
`ifdef MMIO_WR_FIFO_HWM_EN
    .hwm_o       (hwm),
`endif
    .clr_flags_i (clr)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic step(input bit r, input bit p, input logic [WIDTH-1:0] d,
                      input bit po, input bit c);
    bit was_full, ov_ev, ud_ev;
    rst = r; push = p; push_data = d; pop = po; clr = c;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_data = '0; m_ovf = 0; m_udf = 0; m_hwm = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      ov_ev = 0; ud_ev = 0;
      if (po) begin
        if (mq.size() == 0) begin m_data = '0; ud_ev = 1; end
        else m_data = mq.pop_front();
      end
      if (p) begin
        if (!was_full || po) mq.push_back(d);
        else ov_ev = 1;
      end
      m_ovf = ov_ev | (m_ovf & !c);
      m_udf = ud_ev | (m_udf & !c);
      if (c) m_hwm = mq.size();
      else if (mq.size() > m_hwm) m_hwm = mq.size();
    end
    #1;
    rst = 0; push = 0; pop = 0; clr = 0;
  endtask

  task automatic test_reset();
    step(1, 1, 64'hDEAD, 1, 0);
    n_cmp++; if (count !== 0)     begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0)   begin n_bad++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++; if (pop_data !== '0) begin n_bad++; $display("FAIL reset_pop_data got %0h exp 0", pop_data); end
    n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_bad++; $display("FAIL reset_flags got %b%b exp 00", ovf, udf); end
  endtask

  task automatic test_order();
    logic [WIDTH-1:0] exp [3];
    exp[0] = 64'h1111; exp[1] = 64'h2222; exp[2] = 64'h3333;
    for (int i = 0; i < 3; i++) step(0, 1, exp[i], 0, 0);
    n_cmp++; if (count !== 3) begin n_bad++; $display("FAIL order_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 1, 0);
      n_cmp++; if (pop_data !== exp[i]) begin n_bad++; $display("FAIL order_data%0d got %0h exp %0h", i, pop_data, exp[i]); end
      n_cmp++; if (count !== CW'(2 - i)) begin n_bad++; $display("FAIL order_count%0d got %0d exp %0d", i, count, 2 - i); end
    end
    step(0, 0, '0, 0, 0);
    n_cmp++; if (pop_data !== exp[2]) begin n_bad++; $display("FAIL order_hold got %0h exp %0h", pop_data, exp[2]); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL order_empty got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 64'(32'hA0 + i), 0, 0);
      if (i == 7) begin
        n_cmp++; if (full !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_full8 got full=%b ovf=%b exp 1/0", full, ovf); end
      end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 1, 0);
      n_cmp++; if (pop_data !== 64'(32'hA0 + i)) begin n_bad++; $display("FAIL ovf_drain%0d got %0h exp %0h", i, pop_data, 32'hA0 + i); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty got %b exp 1", empty); end
  endtask

  task automatic test_underflow_clr();
    step(0, 0, '0, 1, 0);
    n_cmp++; if (pop_data !== '0) begin n_bad++; $display("FAIL udf_data got %0h exp 0", pop_data); end
    n_cmp++; if (udf !== 1'b1 || ovf !== 1'b1) begin n_bad++; $display("FAIL udf_flags got udf=%b ovf=%b exp 1/1", udf, ovf); end
    step(0, 0, '0, 0, 1);
    n_cmp++; if (udf !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL clr_flags got udf=%b ovf=%b exp 0/0", udf, ovf); end
    n_cmp++; if (count !== 0) begin n_bad++; $display("FAIL clr_count got %0d exp 0", count); end
    // A set event in the clearing cycle wins.
    step(0, 0, '0, 1, 1);
    n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins got %b exp 1", udf); end
    step(0, 0, '0, 0, 1);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) step(0, 1, 64'(32'h50 + i), 0, 0);
    step(0, 1, 64'hBB, 1, 0);
    n_cmp++; if (pop_data !== 64'h50) begin n_bad++; $display("FAIL fpp_data got %0h exp 50", pop_data); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf got %b exp 0", ovf); end
    n_cmp++; if (count !== CW'(DEPTH) || full !== 1'b1) begin n_bad++; $display("FAIL fpp_count got %0d exp %0d", count, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 1, 0);
      n_cmp++;
      if (pop_data !== ((i == 7) ? 64'hBB : 64'(32'h51 + i))) begin
        n_bad++; $display("FAIL fpp_drain%0d got %0h", i, pop_data);
      end
    end
  endtask

  task automatic test_empty_push_pop();
    step(0, 1, 64'hCC, 1, 0);
    n_cmp++; if (pop_data !== '0) begin n_bad++; $display("FAIL epp_data got %0h exp 0", pop_data); end
    n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL epp_udf got %b exp 1", udf); end
    n_cmp++; if (count !== 1) begin n_bad++; $display("FAIL epp_count got %0d exp 1", count); end
    step(0, 0, '0, 1, 0);
    n_cmp++; if (pop_data !== 64'hCC) begin n_bad++; $display("FAIL epp_next got %0h exp cc", pop_data); end
  endtask

  task automatic test_random();
    int push_pct;
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      push_pct = ((i / 100) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 99) < push_pct,
           {$urandom, $urandom}, $urandom_range(0, 99) < (100 - push_pct),
           $urandom_range(0, 24) == 0);
      n_cmp++;
      if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        n_bad++; $display("FAIL rnd_occ cyc %0d got cnt=%0d f=%b e=%b exp cnt=%0d", i, count, full, empty, mq.size());
      end
      n_cmp++;
      if (pop_data !== m_data) begin n_bad++; $display("FAIL rnd_data cyc %0d got %0h exp %0h", i, pop_data, m_data); end
      n_cmp++;
      if (ovf !== m_ovf || udf !== m_udf) begin n_bad++; $display("FAIL rnd_flags cyc %0d got %b%b exp %b%b", i, ovf, udf, m_ovf, m_udf); end
`ifdef MMIO_WR_FIFO_HWM_EN
      n_cmp++;
      if (hwm !== CW'(m_hwm)) begin n_bad++; $display("FAIL rnd_hwm cyc %0d got %0d exp %0d", i, hwm, m_hwm); end
`endif
    end
  endtask

`ifdef MMIO_WR_FIFO_HWM_EN
  task automatic test_hwm();
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 64'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
    n_cmp++; if (hwm !== 5) begin n_bad++; $display("FAIL hwm_peak got %0d exp 5", hwm); end
    step(0, 0, '0, 0, 1);
    n_cmp++; if (hwm !== 2) begin n_bad++; $display("FAIL hwm_clr got %0d exp 2", hwm); end
    step(0, 1, 64'h7, 0, 0);
    step(1, 1, 64'h8, 0, 0);
    n_cmp++; if (count !== 0 || hwm !== 0) begin n_bad++; $display("FAIL hwm_rst got cnt=%0d hwm=%0d exp 0/0", count, hwm); end
  endtask
`endif

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr = 1'b0; push_data = '0;
    test_reset();
    test_order();
    test_overflow();
    test_underflow_clr();
    test_full_push_pop();
    test_empty_push_pop();
    test_random();
`ifdef MMIO_WR_FIFO_HWM_EN
    test_hwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
